sdram_pattern_tester: RTL and testbench

Upstream traffic generator/checker for the 2M x 32 SDRAM controller. After `start`, it writes a 32-bit LFSR pattern across a configurable word range through the controller's valid/ready request port. It then regenerates the same sequence, reads every word back and compares. It reports pass/fail, a saturating error count and the first failing word address, which the board test top maps to LEDs/UART.

---
 rtl/sdram_pattern_tester_if.sv | 19 +
 rtl/sdram_pattern_tester.sv | 216 +++++++++++++++++++++
 tb/tb_sdram_pattern_tester.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_pattern_tester_if.sv
// Valid/ready request port between the pattern tester (master) and the SDRAM controller (slave).
interface sdram_pattern_tester_if;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic [31:0] m_rdata;

    modport master (
        output m_valid, m_addr, m_wdata, m_wstrb,
        input  m_ready, m_rdata
    );

    modport slave (
        input  m_valid, m_addr, m_wdata, m_wstrb,
        output m_ready, m_rdata
    );
endinterface

// File: rtl/sdram_pattern_tester.sv
// LFSR write/read-back tester for the 2M x 32 SDRAM controller.
// Define SDRAM_TEST_LOOP_EN to rerun passes forever with a rotating seed.
module sdram_pattern_tester #(
    parameter int unsigned NUM_WORDS_LOG2 = 21,
    parameter logic [31:0] SEED           = 32'h1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    sdram_pattern_tester_if.master        bus,
    output logic                          busy,
    output logic                          done,
    output logic                          pass_ok,
    output logic [15:0]                   err_count,
    output logic [20:0]                   first_err_addr,
    output logic [15:0]                   pass_count
);

    localparam logic [31:0] SeedInit = (SEED == 32'h0) ? 32'h1 : SEED;
    localparam logic [31:0] LfsrMask = 32'h80200003;

    typedef enum logic [2:0] {StIdle, StWrReq, StWrGap, StRdReq, StRdGap, StDone} state_e;

    function automatic logic [31:0] lfsr_next(input logic [31:0] v);
        return v[0] ? ((v >> 1) ^ LfsrMask) : (v >> 1);
    endfunction

    state_e                      state_q, state_d;
    logic [NUM_WORDS_LOG2-1:0]   word_idx_q, word_idx_d;
    logic [31:0]                 lfsr_q, lfsr_d;
    logic [31:0]                 seed_q, seed_d;
    logic [15:0]                 err_q, err_d;
    logic [20:0]                 first_q, first_d;
    logic                        flag_q, flag_d;
    logic [15:0]                 pass_cnt_q, pass_cnt_d;
    logic                        pass_ok_q, pass_ok_d;
    logic                        busy_q, busy_d;
    logic                        done_q, done_d;
    logic                        valid_q, valid_d;
    logic [31:0]                 addr_q, addr_d;
    logic [31:0]                 wdata_q, wdata_d;
    logic [3:0]                  wstrb_q, wstrb_d;

    logic        hit;
    logic        last;
    logic        launch;
    logic        clear_err;
    logic [31:0] launch_seed;

    always_comb begin
        state_d     = state_q;
        word_idx_d  = word_idx_q;
        lfsr_d      = lfsr_q;
        seed_d      = seed_q;
        err_d       = err_q;
        first_d     = first_q;
        flag_d      = flag_q;
        pass_cnt_d  = pass_cnt_q;
        pass_ok_d   = pass_ok_q;
        valid_d     = valid_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        launch      = 1'b0;
        clear_err   = 1'b0;
        launch_seed = SeedInit;
        // Only a ready that answers an outstanding request counts.
        hit         = valid_q & bus.m_ready;
        last        = &word_idx_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    launch    = 1'b1;
                    clear_err = 1'b1;
                end
            end
            StWrReq: begin
                if (hit) begin
                    valid_d = 1'b0;
                    if (last) begin
                        state_d    = StRdReq;
                        word_idx_d = '0;
                        lfsr_d     = seed_q;
                    end else begin
                        state_d    = StWrGap;
                        word_idx_d = word_idx_q + NUM_WORDS_LOG2'(1);
                        lfsr_d     = lfsr_next(lfsr_q);
                    end
                end
            end
            StWrGap: begin
                state_d = StWrReq;
                valid_d = 1'b1;
                addr_d  = 32'({word_idx_q, 2'b00});
                wdata_d = lfsr_q;
                wstrb_d = 4'hF;
            end
            StRdReq: begin
                if (!valid_q) begin
                    // First read follows the last write ready; raise valid after one idle cycle.
                    valid_d = 1'b1;
                    addr_d  = 32'({word_idx_q, 2'b00});
                    wdata_d = 32'h0;
                    wstrb_d = 4'h0;
                end else if (hit) begin
                    valid_d = 1'b0;
                    lfsr_d  = lfsr_next(lfsr_q);
                    if (bus.m_rdata != lfsr_q) begin
                        err_d = (err_q == 16'hFFFF) ? err_q : err_q + 16'd1;
                        if (!flag_q) begin
                            first_d = 21'(word_idx_q);
                            flag_d  = 1'b1;
                        end
                    end
                    if (last) begin
                        state_d    = StDone;
                        pass_cnt_d = pass_cnt_q + 16'd1;
                        pass_ok_d  = (err_d == 16'h0);
                    end else begin
                        state_d    = StRdGap;
                        word_idx_d = word_idx_q + NUM_WORDS_LOG2'(1);
                    end
                end
            end
            StRdGap: begin
                state_d = StRdReq;
                valid_d = 1'b1;
                addr_d  = 32'({word_idx_q, 2'b00});
                wdata_d = 32'h0;
                wstrb_d = 4'h0;
            end
            StDone: begin
`ifdef SDRAM_TEST_LOOP_EN
                launch      = 1'b1;
                launch_seed = {seed_q[30:0], seed_q[31]};
`else
                if (start) begin
                    launch    = 1'b1;
                    clear_err = 1'b1;
                end
`endif
            end
            default: state_d = StIdle;
        endcase

        if (launch) begin
            state_d    = StWrReq;
            word_idx_d = '0;
            seed_d     = launch_seed;
            lfsr_d     = launch_seed;
            valid_d    = 1'b1;
            addr_d     = 32'h0;
            wdata_d    = launch_seed;
            wstrb_d    = 4'hF;
        end
        if (clear_err) begin
            err_d     = 16'h0;
            first_d   = 21'h0;
            flag_d    = 1'b0;
            pass_ok_d = 1'b0;
        end

        busy_d = (state_d == StWrReq) || (state_d == StWrGap) ||
                 (state_d == StRdReq) || (state_d == StRdGap);
        done_d = (state_d == StDone);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            word_idx_q <= '0;
            lfsr_q     <= SeedInit;
            seed_q     <= SeedInit;
            err_q      <= 16'h0;
            first_q    <= 21'h0;
            flag_q     <= 1'b0;
            pass_cnt_q <= 16'h0;
            pass_ok_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            valid_q    <= 1'b0;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            wstrb_q    <= 4'h0;
        end else begin
            state_q    <= state_d;
            word_idx_q <= word_idx_d;
            lfsr_q     <= lfsr_d;
            seed_q     <= seed_d;
            err_q      <= err_d;
            first_q    <= first_d;
            flag_q     <= flag_d;
            pass_cnt_q <= pass_cnt_d;
            pass_ok_q  <= pass_ok_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            valid_q    <= valid_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
        end
    end

    assign bus.m_valid    = valid_q;
    assign bus.m_addr     = addr_q;
    assign bus.m_wdata    = wdata_q;
    assign bus.m_wstrb    = wstrb_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass_ok        = pass_ok_q;
    assign err_count      = err_q;
    assign first_err_addr = first_q;
    assign pass_count     = pass_cnt_q;

endmodule

// File: tb/tb_sdram_pattern_tester.sv
// Scoreboard bench: expected requests are queued per pass; a memory-model responder pops and checks.
module tb_sdram_pattern_tester;

    localparam int NW = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        busy, done, pass_ok;
    logic [15:0] err_count, pass_count;
    logic [20:0] first_err_addr;

    sdram_pattern_tester_if bus ();

    sdram_pattern_tester #(
        .NUM_WORDS_LOG2 (4),
        .SEED           (32'h1)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .bus            (bus),
        .busy           (busy),
        .done           (done),
        .pass_ok        (pass_ok),
        .err_count      (err_count),
        .first_err_addr (first_err_addr),
        .pass_count     (pass_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  strb;
        logic [31:0] addr;
        logic [31:0] data;
    } req_t;

    req_t        exp_q[$];
    logic [31:0] first_wdata_log[$];
    logic [31:0] mem [NW];
    int          n_checks = 0;
    int          n_fail = 0;
    int          fault_mode = 0;   // 0 ideal, 1 flip bit 7 of word 5, 2 stuck-at-zero
    int          lat_mode = 0;     // 0 fixed 5 cycles, 1 random 1..30
    bit          expect_traffic = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] lfsr_step(input logic [31:0] v);
        return v[0] ? ((v >> 1) ^ 32'h80200003) : (v >> 1);
    endfunction

    task automatic push_pass(input logic [31:0] seed);
        logic [31:0] hand [4];
        logic [31:0] v;
        hand = '{32'h1, 32'h80200003, 32'hC0300002, 32'h60180001};
        v = seed;
        for (int i = 0; i < NW; i++) begin
            exp_q.push_back('{strb: 4'hF, addr: 32'(i * 4),
                              data: (seed == 32'h1 && i < 4) ? hand[i] : v});
            v = lfsr_step(v);
        end
        for (int i = 0; i < NW; i++) exp_q.push_back('{strb: 4'h0, addr: 32'(i * 4), data: 32'h0});
    endtask

    // Memory model / monitor: pops the expected request when valid first appears.
    initial begin : responder
        bit   active;
        int   cnt;
        int   w;
        req_t cur;
        req_t e;
        active = 1'b0;
        cnt = 0;
        bus.m_ready = 1'b0;
        bus.m_rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                active = 1'b0;
                bus.m_ready = 1'b0;
            end else if (bus.m_ready) begin
                bus.m_ready = 1'b0;
                check("valid_low_after_ready", bus.m_valid, 1'b0);
            end else if (bus.m_valid) begin
                if (!active) begin
                    active = 1'b1;
                    cnt = (lat_mode == 0) ? 5 : int'($urandom_range(30, 1));
                    cur = '{strb: bus.m_wstrb, addr: bus.m_addr, data: bus.m_wdata};
                    if (exp_q.size() == 0) begin
                        if (expect_traffic) check("unexpected_request", bus.m_addr, 32'hFFFFFFFF);
                    end else begin
                        e = exp_q.pop_front();
                        check("req_wstrb", bus.m_wstrb, e.strb);
                        check("req_addr", bus.m_addr, e.addr);
                        if (e.strb == 4'hF) check("req_wdata", bus.m_wdata, e.data);
                    end
                    if (cur.strb == 4'hF && cur.addr == 32'h0) first_wdata_log.push_back(cur.data);
                end else begin
                    check("hold_addr", bus.m_addr, cur.addr);
                    check("hold_wdata", bus.m_wdata, cur.data);
                    check("hold_wstrb", bus.m_wstrb, cur.strb);
                end
                cnt--;
                if (cnt <= 0) begin
                    w = int'(cur.addr[5:2]);
                    if (cur.strb == 4'hF) mem[w] = cur.data;
                    else if (fault_mode == 2) bus.m_rdata = 32'h0;
                    else if (fault_mode == 1 && w == 5) bus.m_rdata = mem[w] ^ 32'h80;
                    else bus.m_rdata = mem[w];
                    bus.m_ready = 1'b1;
                    active = 1'b0;
                end
            end
        end
    end

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_pass(input string tag, input logic [15:0] exp_err, input logic [20:0] exp_first,
                            input logic exp_ok, input logic [15:0] exp_pc);
        int c;
        push_pass(32'h1);
        pulse_start();
        c = 0;
        while (!done && c < 4000) begin
            @(negedge clk);
            c++;
        end
        $display("run %s finished after %0d cycles", tag, c);
        check({tag, "_done"}, done, 1'b1);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_err_count"}, err_count, exp_err);
        check({tag, "_first_err_addr"}, first_err_addr, exp_first);
        check({tag, "_pass_ok"}, pass_ok, exp_ok);
        check({tag, "_pass_count"}, pass_count, exp_pc);
        check({tag, "_queue_drained"}, exp_q.size(), 0);
    endtask

    initial begin : stimulus
        int c;
        int seen;
        rst_n = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_m_valid", bus.m_valid, 1'b0);
        check("rst_m_addr", bus.m_addr, 32'h0);
        check("rst_m_wdata", bus.m_wdata, 32'h0);
        check("rst_m_wstrb", bus.m_wstrb, 4'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_pass_ok", pass_ok, 1'b0);
        check("rst_err_count", err_count, 16'h0);
        check("rst_first_err_addr", first_err_addr, 21'h0);
        check("rst_pass_count", pass_count, 16'h0);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.m_valid) seen++;
        end
        check("idle_no_valid", seen, 0);

`ifdef SDRAM_TEST_LOOP_EN
        push_pass(32'h1);
        push_pass(32'h2);
        push_pass(32'h4);
        pulse_start();
        c = 0;
        while (pass_count != 16'd3 && c < 8000) begin
            @(negedge clk);
            c++;
        end
        expect_traffic = 1'b0;
        check("loop_pass_count", pass_count, 16'd3);
        check("loop_done_pulse", done, 1'b1);
        check("loop_err_count", err_count, 16'h0);
        check("loop_pass_ok", pass_ok, 1'b1);
        check("loop_queue_drained", exp_q.size(), 0);
        check("loop_pass1_first_wdata", first_wdata_log[0], 32'h1);
        check("loop_pass2_first_wdata", first_wdata_log[1], 32'h2);
        @(negedge clk);
        check("loop_done_transient", done, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
`else
        run_pass("clean", 16'd0, 21'd0, 1'b1, 16'd1);
        fault_mode = 1;
        run_pass("flip", 16'd1, 21'd5, 1'b0, 16'd2);
        fault_mode = 2;
        run_pass("stuck", 16'd16, 21'd0, 1'b0, 16'd3);
        fault_mode = 0;
        lat_mode = 1;
        run_pass("random_lat", 16'd0, 21'd0, 1'b1, 16'd4);
        lat_mode = 0;

        // Reset while word 9 is being written, then restart from word 0.
        push_pass(32'h1);
        pulse_start();
        c = 0;
        while (!(bus.m_valid && bus.m_addr == 32'h24 && bus.m_wstrb == 4'hF) && c < 1000) begin
            @(negedge clk);
            c++;
        end
        check("midrun_reached_word9", bus.m_addr, 32'h24);
        rst_n = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("midrun_rst_m_valid", bus.m_valid, 1'b0);
        check("midrun_rst_busy", busy, 1'b0);
        check("midrun_rst_pass_count", pass_count, 16'h0);
        check("midrun_rst_m_addr", bus.m_addr, 32'h0);
        rst_n = 1'b1;
        first_wdata_log.delete();
        run_pass("restart", 16'd0, 21'd0, 1'b1, 16'd1);
        check("restart_first_wdata", first_wdata_log[0], 32'h1);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
